cdb_writeback_arbiter: RTL and testbench

Result-writeback stage between the functional units (ALU, branch, load unit, store-address unit) and the reorder buffer. Each unit hands over a completed result (RoB tag plus value). The block buffers one result per unit and grants one result per cycle onto the registered common data bus (CDB). The RoB uses the CDB to set `RoB_Valid`/`RoB_Dest_Value`; reservation stations snoop it for operand wake-up. The commit stage consumes only entries this block has marked valid.

---
 rtl/cdb_writeback_arbiter.sv | 122 ++++++++++++
 tb/tb_cdb_writeback_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_writeback_arbiter.sv
// Writeback arbiter: one holding slot per functional unit, one grant per cycle onto a registered CDB.
// Define CDB_AGE_PRIORITY_EN to grant the oldest pending result (relative to rob_head) instead of round-robin.
module cdb_writeback_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int TAG_W   = 7,
  parameter int DATA_W  = 32,
  parameter int SRC_W   = $clog2(NUM_SRC)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [TAG_W-1:0]          rob_head,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic [NUM_SRC*TAG_W-1:0]  src_tag,
  input  logic [NUM_SRC*DATA_W-1:0] src_value,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_value,
  output logic [SRC_W-1:0]          cdb_src
);

  logic [NUM_SRC-1:0] hold_valid;
  logic [TAG_W-1:0]   hold_tag   [NUM_SRC];
  logic [DATA_W-1:0]  hold_value [NUM_SRC];

  logic [NUM_SRC-1:0] grant;
  logic [SRC_W-1:0]   grant_idx;
  logic               grant_found;

`ifdef CDB_AGE_PRIORITY_EN
  // Strict less-than keeps the lowest index on an (impossible) age tie.
  always_comb begin
    logic [TAG_W-1:0] age;
    logic [TAG_W-1:0] best_age;
    grant       = '0;
    grant_idx   = '0;
    grant_found = 1'b0;
    age         = '0;
    best_age    = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      age = hold_tag[i] - rob_head;
      if (hold_valid[i] && (!grant_found || age < best_age)) begin
        grant_found = 1'b1;
        grant_idx   = SRC_W'(i);
        best_age    = age;
      end
    end
    if (grant_found) grant[grant_idx] = 1'b1;
  end
`else
  logic [SRC_W-1:0] rr_ptr;
  logic             unused_rob_head;

  assign unused_rob_head = ^rob_head;

  always_comb begin
    int idx;
    grant       = '0;
    grant_idx   = '0;
    grant_found = 1'b0;
    idx         = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_SRC;
      if (!grant_found && hold_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = SRC_W'(idx);
      end
    end
    if (grant_found) grant[grant_idx] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset || flush) begin
      rr_ptr <= '0;
    end else if (grant_found) begin
      rr_ptr <= (grant_idx == SRC_W'(NUM_SRC - 1)) ? '0 : grant_idx + SRC_W'(1);
    end
  end
`endif

  // A slot being granted this cycle frees up in time to take the next result.
  assign src_ready = {NUM_SRC{!flush}} & (~hold_valid | grant);

  always_ff @(posedge clock) begin
    if (!reset) begin
      hold_valid <= '0;
      cdb_valid  <= 1'b0;
      cdb_tag    <= '0;
      cdb_value  <= '0;
      cdb_src    <= '0;
    end else if (flush) begin
      hold_valid <= '0;
      cdb_valid  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (src_valid[i] && src_ready[i]) begin
          hold_valid[i] <= 1'b1;
        end else if (grant[i]) begin
          hold_valid[i] <= 1'b0;
        end
      end
      cdb_valid <= grant_found;
      if (grant_found) begin
        cdb_tag   <= hold_tag[grant_idx];
        cdb_value <= hold_value[grant_idx];
        cdb_src   <= grant_idx;
      end
    end
  end

  // Slot payload needs no reset; hold_valid qualifies it.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_valid[i] && src_ready[i]) begin
        hold_tag[i]   <= src_tag[i*TAG_W +: TAG_W];
        hold_value[i] <= src_value[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_cdb_writeback_arbiter.sv
// Self-checking bench for cdb_writeback_arbiter: directed scenarios plus randomized traffic
// checked against a slot/queue-level reference model (honours CDB_AGE_PRIORITY_EN).
module tb_cdb_writeback_arbiter;

  localparam int NS = 4;
  localparam int TW = 7;
  localparam int DW = 32;
  localparam int SW = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              flush = 1'b0;
  logic [TW-1:0]     rob_head = '0;
  logic [NS-1:0]     src_valid = '0;
  logic [NS-1:0]     src_ready;
  logic [NS*TW-1:0]  src_tag = '0;
  logic [NS*DW-1:0]  src_value = '0;
  logic              cdb_valid;
  logic [TW-1:0]     cdb_tag;
  logic [DW-1:0]     cdb_value;
  logic [SW-1:0]     cdb_src;

  cdb_writeback_arbiter #(.NUM_SRC(NS), .TAG_W(TW), .DATA_W(DW)) dut (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .rob_head (rob_head),
    .src_valid(src_valid),
    .src_ready(src_ready),
    .src_tag  (src_tag),
    .src_value(src_value),
    .cdb_valid(cdb_valid),
    .cdb_tag  (cdb_tag),
    .cdb_value(cdb_value),
    .cdb_src  (cdb_src)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model: pending results per source plus the last broadcast.
  bit            m_valid [NS];
  logic [TW-1:0] m_tag   [NS];
  logic [DW-1:0] m_value [NS];
  int            m_ptr   = 0;
  bit            m_cv    = 0;
  logic [TW-1:0] m_ct    = '0;
  logic [DW-1:0] m_cval  = '0;
  int            m_cs    = 0;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic int pickGrant(input logic [TW-1:0] head);
    int best = -1;
`ifdef CDB_AGE_PRIORITY_EN
    int best_age = 0;
    for (int i = 0; i < NS; i++) begin
      int age = (int'(m_tag[i]) - int'(head) + (1 << TW)) % (1 << TW);
      if (m_valid[i] && (best < 0 || age < best_age)) begin
        best = i;
        best_age = age;
      end
    end
`else
    for (int k = 0; k < NS; k++) begin
      int j = (m_ptr + k) % NS;
      if (best < 0 && m_valid[j]) best = j;
    end
`endif
    return best;
  endfunction

  // One clock cycle: drive at the falling edge, check ready before the rising edge,
  // check the CDB just after it, then return at the next falling edge.
  task automatic applyStimulus(input logic [NS-1:0] v, input logic [NS*TW-1:0] tags,
                               input logic [NS*DW-1:0] vals, input logic fl,
                               input logic rst_n, input logic [TW-1:0] head,
                               output logic [NS-1:0] acc);
    logic [NS-1:0] exp_ready;
    int g;
    src_valid = v;
    src_tag   = tags;
    src_value = vals;
    flush     = fl;
    reset     = rst_n;
    rob_head  = head;
    #1;
    g = pickGrant(head);
    for (int i = 0; i < NS; i++) exp_ready[i] = !fl && (!m_valid[i] || g == i);
    checkOutput("src_ready", 64'(src_ready), 64'(exp_ready));
    acc = v & exp_ready;
    if (!rst_n) begin
      for (int i = 0; i < NS; i++) m_valid[i] = 0;
      m_cv = 0; m_ct = '0; m_cval = '0; m_cs = 0; m_ptr = 0;
    end else if (fl) begin
      for (int i = 0; i < NS; i++) m_valid[i] = 0;
      m_cv = 0; m_ptr = 0;
    end else begin
      if (g >= 0) begin
        m_cv = 1; m_ct = m_tag[g]; m_cval = m_value[g]; m_cs = g;
        m_ptr = (g + 1) % NS;
        m_valid[g] = 0;
      end else begin
        m_cv = 0;
      end
      for (int i = 0; i < NS; i++) begin
        if (acc[i]) begin
          m_valid[i] = 1;
          m_tag[i]   = tags[i*TW +: TW];
          m_value[i] = vals[i*DW +: DW];
        end
      end
    end
    @(posedge clock);
    #1;
    checkOutput("cdb_valid", 64'(cdb_valid), 64'(m_cv));
    checkOutput("cdb_tag",   64'(cdb_tag),   64'(m_ct));
    checkOutput("cdb_value", 64'(cdb_value), 64'(m_cval));
    checkOutput("cdb_src",   64'(cdb_src),   64'(m_cs));
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    logic [NS-1:0] acc;
    for (int i = 0; i < n; i++) applyStimulus('0, '0, '0, 1'b0, 1'b1, '0, acc);
  endtask

  initial begin
    logic [NS-1:0]    acc;
    logic [NS*TW-1:0] tg;
    logic [NS*DW-1:0] vl;
    bit               off_v [NS];
    logic [TW-1:0]    off_t [NS];
    logic [DW-1:0]    off_d [NS];

    for (int i = 0; i < NS; i++) begin
      m_valid[i] = 0; m_tag[i] = '0; m_value[i] = '0; off_v[i] = 0; off_t[i] = '0; off_d[i] = '0;
    end

    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("reset_cdb_valid", 64'(cdb_valid), 64'd0);
    checkOutput("reset_cdb_tag",   64'(cdb_tag),   64'd0);
    checkOutput("reset_cdb_value", 64'(cdb_value), 64'd0);
    checkOutput("reset_cdb_src",   64'(cdb_src),   64'd0);
    reset = 1'b1;

    $display("[TB] single result");
    tg = '0; vl = '0;
    tg[2*TW +: TW] = 7'd5;
    vl[2*DW +: DW] = 32'hDEADBEEF;
    applyStimulus(4'b0100, tg, vl, 1'b0, 1'b1, '0, acc);
    checkOutput("single_no_early", 64'(cdb_valid), 64'd0);
    idle(1);
    checkOutput("single_valid", 64'(cdb_valid), 64'd1);
    checkOutput("single_tag",   64'(cdb_tag),   64'd5);
    checkOutput("single_value", 64'(cdb_value), 64'hDEADBEEF);
    checkOutput("single_src",   64'(cdb_src),   64'd2);
    idle(1);
    checkOutput("single_one_cycle", 64'(cdb_valid), 64'd0);

    $display("[TB] round-robin contention");
    applyStimulus('0, '0, '0, 1'b1, 1'b1, '0, acc);
    for (int i = 0; i < NS; i++) begin
      tg[i*TW +: TW] = TW'(10 + i);
      vl[i*DW +: DW] = 32'h1000 + DW'(i);
    end
    applyStimulus(4'b1111, tg, vl, 1'b0, 1'b1, '0, acc);
    for (int k = 0; k < NS; k++) begin
      idle(1);
      checkOutput("rr_valid", 64'(cdb_valid), 64'd1);
      checkOutput("rr_src",   64'(cdb_src),   64'(k));
      checkOutput("rr_tag",   64'(cdb_tag),   64'(10 + k));
    end
    idle(1);
    checkOutput("rr_drain", 64'(cdb_valid), 64'd0);

    $display("[TB] back-to-back throughput");
    for (int k = 0; k < 8; k++) begin
      tg = '0; vl = '0;
      tg[TW-1:0] = TW'(k);
      vl[DW-1:0] = $urandom;
      applyStimulus(4'b0001, tg, vl, 1'b0, 1'b1, '0, acc);
      checkOutput("tp_ready", 64'(acc[0]), 64'd1);
      if (k >= 1) checkOutput("tp_tag", 64'(cdb_tag), 64'(k - 1));
    end
    idle(1);
    checkOutput("tp_last", 64'(cdb_tag), 64'd7);

    $display("[TB] flush");
    idle(1);
    tg = '0; vl = '0;
    tg[1*TW +: TW] = 7'd30; tg[3*TW +: TW] = 7'd31;
    vl[1*DW +: DW] = 32'hAAAA; vl[3*DW +: DW] = 32'hBBBB;
    applyStimulus(4'b1010, tg, vl, 1'b0, 1'b1, '0, acc);
    applyStimulus('0, '0, '0, 1'b1, 1'b1, '0, acc);
    checkOutput("flush_cdb_valid", 64'(cdb_valid), 64'd0);
    for (int k = 0; k < 3; k++) begin
      idle(1);
      checkOutput("flush_no_stale", 64'(cdb_valid), 64'd0);
    end
    tg = '0; vl = '0;
    tg[TW-1:0] = 7'd20; vl[DW-1:0] = 32'h2020;
    applyStimulus(4'b0001, tg, vl, 1'b0, 1'b1, '0, acc);
    idle(1);
    checkOutput("flush_new_tag", 64'(cdb_tag), 64'd20);
    checkOutput("flush_new_src", 64'(cdb_src), 64'd0);

    $display("[TB] reset mid-operation");
    tg = '0; vl = '0;
    for (int i = 0; i < 3; i++) begin
      tg[i*TW +: TW] = TW'(40 + i);
      vl[i*DW +: DW] = 32'h4000 + DW'(i);
    end
    applyStimulus(4'b0111, tg, vl, 1'b0, 1'b1, '0, acc);
    idle(1);
    checkOutput("rst_pre_valid", 64'(cdb_valid), 64'd1);
    applyStimulus('0, '0, '0, 1'b0, 1'b0, '0, acc);
    checkOutput("rst_valid", 64'(cdb_valid), 64'd0);
    checkOutput("rst_tag",   64'(cdb_tag),   64'd0);
    checkOutput("rst_value", 64'(cdb_value), 64'd0);
    checkOutput("rst_src",   64'(cdb_src),   64'd0);
    for (int k = 0; k < 3; k++) begin
      idle(1);
      checkOutput("rst_no_stale", 64'(cdb_valid), 64'd0);
    end

`ifdef CDB_AGE_PRIORITY_EN
    $display("[TB] age priority");
    tg = '0; vl = '0;
    tg[0*TW +: TW] = 7'd3; tg[1*TW +: TW] = 7'd127;
    applyStimulus(4'b0011, tg, vl, 1'b0, 1'b1, 7'd126, acc);
    applyStimulus('0, '0, '0, 1'b0, 1'b1, 7'd126, acc);
    checkOutput("age_first_src", 64'(cdb_src), 64'd1);
    applyStimulus('0, '0, '0, 1'b0, 1'b1, 7'd126, acc);
    checkOutput("age_second_src", 64'(cdb_src), 64'd0);
`endif

    $display("[TB] randomized traffic");
    for (int c = 0; c < 500; c++) begin
      logic fl;
      logic rn;
      logic [NS-1:0] v;
      for (int i = 0; i < NS; i++) begin
        if (!off_v[i] && $urandom_range(99) < 55) begin
          off_v[i] = 1; off_t[i] = TW'($urandom); off_d[i] = $urandom;
        end else if (off_v[i] && $urandom_range(99) < 8) begin
          off_v[i] = 0;
        end
        v[i] = off_v[i];
        tg[i*TW +: TW] = off_t[i];
        vl[i*DW +: DW] = off_d[i];
      end
      fl = ($urandom_range(99) < 3);
      rn = !($urandom_range(99) < 2);
      applyStimulus(v, tg, vl, fl, rn, TW'($urandom), acc);
      for (int i = 0; i < NS; i++) if (acc[i]) off_v[i] = 0;
    end
    idle(NS + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
